io_terminal_controller: RTL and testbench

Bridges a byte-stream host terminal to the machine's INPR/OUTR character path. It buffers host bytes in an RX FIFO and delivers them one at a time through the FGI handshake: drive data, pulse load, wait for FGI. It captures OUTR characters via the FGO handshake into a TX FIFO for the host to drain. It sits beside the control unit: its load/clear outputs drive the control unit's load_in/clear_in, and its inpr_data_out feeds the INPR register data input.

---
 rtl/io_terminal_controller.sv | 172 +++++++++++++++++
 tb/tb_io_terminal_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/io_terminal_controller.sv
// Terminal bridge between a host byte stream and the INPR/OUTR character path.
// The RX FIFO feeds INPR through the FGI handshake; the TX FIFO captures OUTR through the FGO handshake.
module io_terminal_controller #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock_in,
  input  logic                       reset_n_in,
  input  logic                       boot_in,
  input  logic [WIDTH-1:0]           rx_data_in,
  input  logic                       rx_valid_in,
  output logic                       rx_ready_out,
  output logic [WIDTH-1:0]           tx_data_out,
  output logic                       tx_valid_out,
  input  logic                       tx_ready_in,
  input  logic                       fgi_in,
  input  logic                       fgo_in,
  input  logic [WIDTH-1:0]           outr_in,
  output logic [WIDTH-1:0]           inpr_data_out,
  output logic                       load_out,
  output logic                       clear_out,
  output logic [$clog2(DEPTH+1)-1:0] rx_count_out,
  output logic [$clog2(DEPTH+1)-1:0] tx_count_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_LOAD, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_ACK, TX_WAIT} tx_state_t;

  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [PW-1:0]    rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0]    rx_count, rx_count_nxt;
  logic             rx_ready_q, rx_push, rx_pop, rx_start;
  rx_state_t        rx_state, rx_state_nxt;

  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [PW-1:0]    tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0]    tx_count, tx_count_nxt;
  logic             tx_push, tx_pop;
  tx_state_t        tx_state, tx_state_nxt;

  // ---- RX path: host -> FIFO -> INPR ----
  // Ready comes from a register, so a pop in the same cycle never frees a slot early.
  assign rx_ready_out = rx_ready_q && !boot_in;
  assign rx_push      = rx_valid_in && rx_ready_out;
  assign rx_pop       = (rx_state == RX_LOAD) && !boot_in;
  assign rx_count_out = rx_count;

  always_comb begin
    rx_count_nxt = rx_count;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_nxt = rx_count + CW'(1);
      2'b01:   rx_count_nxt = rx_count - CW'(1);
      default: rx_count_nxt = rx_count;
    endcase
  end

  always_comb begin
    rx_state_nxt = rx_state;
    load_out     = 1'b0;
    rx_start     = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_count != '0 && !fgi_in) begin
        rx_state_nxt = RX_LOAD;
        rx_start     = 1'b1;
      end
      RX_LOAD: begin
        load_out     = 1'b1;
        rx_state_nxt = RX_WAIT;
      end
      // Wait for FGI to rise so the flag latency cannot trigger a second load.
      RX_WAIT: if (fgi_in) rx_state_nxt = RX_IDLE;
      default: rx_state_nxt = RX_IDLE;
    endcase
    if (boot_in) begin
      rx_state_nxt = RX_IDLE;
      load_out     = 1'b0;
      rx_start     = 1'b0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rx_state      <= RX_IDLE;
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      rx_count      <= '0;
      rx_ready_q    <= 1'b0;
      inpr_data_out <= '0;
    end else if (boot_in) begin
      rx_state      <= RX_IDLE;
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      rx_count      <= '0;
      rx_ready_q    <= 1'b0;
      inpr_data_out <= '0;
    end else begin
      rx_state   <= rx_state_nxt;
      rx_count   <= rx_count_nxt;
      rx_ready_q <= (rx_count_nxt != FULL);
      if (rx_push)  rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)   rx_rd_ptr <= rx_rd_ptr + PW'(1);
      if (rx_start) inpr_data_out <= rx_mem[rx_rd_ptr];
    end
  end

  always_ff @(posedge clock_in) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data_in;
  end

  // ---- TX path: OUTR -> FIFO -> host ----
  assign tx_valid_out = (tx_count != '0);
  assign tx_data_out  = tx_valid_out ? tx_mem[tx_rd_ptr] : '0;
  assign tx_pop       = tx_valid_out && tx_ready_in && !boot_in;
  assign tx_push      = (tx_state == TX_ACK) && !boot_in;
  assign tx_count_out = tx_count;

  always_comb begin
    tx_count_nxt = tx_count;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_nxt = tx_count + CW'(1);
      2'b01:   tx_count_nxt = tx_count - CW'(1);
      default: tx_count_nxt = tx_count;
    endcase
  end

  // A full FIFO holds the FSM in idle; FGO stays low so the CPU stalls instead of losing data.
  always_comb begin
    tx_state_nxt = tx_state;
    clear_out    = 1'b0;
    case (tx_state)
      TX_IDLE: if (!fgo_in && tx_count != FULL) tx_state_nxt = TX_ACK;
      TX_ACK: begin
        clear_out    = 1'b1;
        tx_state_nxt = TX_WAIT;
      end
      TX_WAIT: if (fgo_in) tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
    if (boot_in) begin
      tx_state_nxt = TX_IDLE;
      clear_out    = 1'b0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      tx_state  <= TX_IDLE;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (boot_in) begin
      tx_state  <= TX_IDLE;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_count <= tx_count_nxt;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clock_in) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= outr_in;
  end

endmodule

// File: tb/tb_io_terminal_controller.sv
// Randomized bench for io_terminal_controller: emulates host, FGI/FGO flags and CPU output,
// and compares every output each cycle against a queue-based model of the two character paths.
module tb_io_terminal_controller;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int NCYC  = 1800;

  logic             clock_in = 1'b0;
  logic             reset_n_in, boot_in;
  logic [WIDTH-1:0] rx_data_in, outr_in, tx_data_out, inpr_data_out;
  logic             rx_valid_in, rx_ready_out, tx_valid_out, tx_ready_in;
  logic             fgi_in, fgo_in, load_out, clear_out;
  logic [CW-1:0]    rx_count_out, tx_count_out;

  always #5 clock_in = ~clock_in;

  io_terminal_controller #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock_in      (clock_in),
    .reset_n_in    (reset_n_in),
    .boot_in       (boot_in),
    .rx_data_in    (rx_data_in),
    .rx_valid_in   (rx_valid_in),
    .rx_ready_out  (rx_ready_out),
    .tx_data_out   (tx_data_out),
    .tx_valid_out  (tx_valid_out),
    .tx_ready_in   (tx_ready_in),
    .fgi_in        (fgi_in),
    .fgo_in        (fgo_in),
    .outr_in       (outr_in),
    .inpr_data_out (inpr_data_out),
    .load_out      (load_out),
    .clear_out     (clear_out),
    .rx_count_out  (rx_count_out),
    .tx_count_out  (tx_count_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: character queues plus handshake bookkeeping.
  logic [WIDTH-1:0] rxq[$];
  logic [WIDTH-1:0] txq[$];
  logic [WIDTH-1:0] m_inpr;
  bit m_rx_ready, m_rx_load, m_rx_wait, m_tx_ack, m_tx_wait;

  // Flag / CPU emulation state.
  int fgi_rise = -1, fgi_fall = -1, fgo_rise = -1, boot_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_inpr     = '0;
    m_rx_ready = 1'b0;
    m_rx_load  = 1'b0;
    m_rx_wait  = 1'b0;
    m_tx_ack   = 1'b0;
    m_tx_wait  = 1'b0;
  endtask

  task automatic emu_reset();
    fgi_in    = 1'b0;
    fgo_in    = 1'b1;
    fgi_rise  = -1;
    fgi_fall  = -1;
    fgo_rise  = -1;
    boot_left = 0;
  endtask

  task automatic check_outputs();
    logic [WIDTH-1:0] exp_tx;
    exp_tx = (txq.size() != 0) ? txq[0] : '0;
    chk("load_out",     32'(load_out),      32'(m_rx_load && !boot_in));
    chk("clear_out",    32'(clear_out),     32'(m_tx_ack && !boot_in));
    chk("rx_ready_out", 32'(rx_ready_out),  32'(m_rx_ready && !boot_in));
    chk("inpr_data",    32'(inpr_data_out), 32'(m_inpr));
    chk("tx_valid_out", 32'(tx_valid_out),  32'(txq.size() != 0));
    chk("tx_data_out",  32'(tx_data_out),   32'(exp_tx));
    chk("rx_count_out", 32'(rx_count_out),  32'(rxq.size()));
    chk("tx_count_out", 32'(tx_count_out),  32'(txq.size()));
  endtask

  task automatic pick_inputs(input int cyc);
    if (cyc == 5) boot_left = 3;
    else if (boot_left == 0 && $urandom_range(0, 199) == 0) boot_left = $urandom_range(1, 3);
    if (boot_left > 0) begin
      boot_in = 1'b1;
      boot_left--;
    end else begin
      boot_in = 1'b0;
    end

    rx_valid_in = ($urandom_range(0, 2) != 0);
    rx_data_in  = WIDTH'($urandom);
    tx_ready_in = ((cyc / 150) % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));

    // FGI: set shortly after a load, cleared by the CPU later (sometimes much later).
    if (fgi_fall > 0) fgi_fall--;
    else if (fgi_fall == 0) begin
      fgi_in   = 1'b0;
      fgi_fall = -1;
    end
    if (m_rx_load) fgi_rise = $urandom_range(0, 2);
    if (fgi_rise > 0) fgi_rise--;
    else if (fgi_rise == 0) begin
      fgi_in   = 1'b1;
      fgi_rise = -1;
      fgi_fall = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 6);
    end

    // FGO: set shortly after a clear; the CPU then writes a new OUTR character.
    if (m_tx_ack) fgo_rise = $urandom_range(0, 2);
    if (fgo_rise > 0) fgo_rise--;
    else if (fgo_rise == 0) begin
      fgo_in   = 1'b1;
      fgo_rise = -1;
    end else if (fgo_in && $urandom_range(0, 3) == 0) begin
      fgo_in  = 1'b0;
      outr_in = WIDTH'($urandom);
    end
  endtask

  // Advance the model across the coming rising edge using the inputs just driven.
  task automatic model_advance();
    int old_rx, old_tx;
    bit start_load, start_ack;
    if (boot_in) begin
      model_reset();
      return;
    end
    old_rx = rxq.size();
    old_tx = txq.size();

    start_load = !m_rx_load && !m_rx_wait && old_rx != 0 && !fgi_in;
    if (start_load) m_inpr = rxq[0];
    if (m_rx_load) void'(rxq.pop_front());
    if (rx_valid_in && m_rx_ready) rxq.push_back(rx_data_in);
    m_rx_wait  = m_rx_load || (m_rx_wait && !fgi_in);
    m_rx_load  = start_load;
    m_rx_ready = (rxq.size() != DEPTH);

    start_ack = !m_tx_ack && !m_tx_wait && !fgo_in && old_tx != DEPTH;
    if (old_tx != 0 && tx_ready_in) void'(txq.pop_front());
    if (m_tx_ack) txq.push_back(outr_in);
    m_tx_wait = m_tx_ack || (m_tx_wait && !fgo_in);
    m_tx_ack  = start_ack;
  endtask

  initial begin
    reset_n_in  = 1'b0;
    boot_in     = 1'b0;
    rx_valid_in = 1'b0;
    rx_data_in  = '0;
    tx_ready_in = 1'b0;
    outr_in     = '0;
    emu_reset();
    model_reset();
    repeat (2) @(negedge clock_in);
    check_outputs();
    reset_n_in = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc == 700) begin
        // Asynchronous reset in the middle of traffic, away from any clock edge.
        #2 reset_n_in = 1'b0;
        boot_in     = 1'b0;
        rx_valid_in = 1'b0;
        tx_ready_in = 1'b0;
        emu_reset();
        #1;
        model_reset();
        check_outputs();
        @(negedge clock_in);
        reset_n_in = 1'b1;
      end
      check_outputs();
      pick_inputs(cyc);
      model_advance();
      @(negedge clock_in);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
